processing_unit: RTL and testbench
==================================

# processing_unit

Datapath of the 8-bit RISC CPU; the receiving end of the control unit's load/select/increment strobes. It holds R0–R3, PC, IR, the ALU operand register Y, the zero flag Z and the memory address register, and routes data over two internal buses. It returns the current instruction and the zero flag to the control unit, and presents address and write data to memory.

## Interface
- word_size, 8, data/address/instruction width
- opcode_size, 4, IR[7:4] opcode field width
- sel1_size, 3, bus-1 mux select width
- sel2_size, 2, bus-2 mux select width
- clk  in  1  rising-edge clock
- rst  in  1  reset; **one clock; reset is synchronous and active-low**
- load_r0, load_r1, load_r2, load_r3  in  1 each  load Rn from bus_2
- load_pc  in  1  load PC from bus_2
- inc_pc  in  1  PC <= PC+1
- load_ir  in  1  load IR from bus_2
- load_y  in  1  load Y from bus_2
- load_z  in  1  load Z from (alu_out == 0)
- load_addr_reg  in  1  load address register from bus_2
- sel_bus_1_mux  in  3  0=R0, 1=R1, 2=R2, 3=R3, 4=PC
- sel_bus_2_mux  in  2  0=alu_out, 1=bus_1, 2=mem_word
- mem_word  in  8  read data from memory
- instruction  out  8  IR contents
- zero  out  1  Z flag
- address  out  8  address register contents
- bus_1  out  8  bus-1 value; memory write data

## Operation
- All state registers (R0–R3, PC, IR, Y, Z, address reg) update only at the rising clk edge, only while their load/inc strobe is 1; otherwise they hold.
- bus_1 is combinational from sel_bus_1_mux. Codes 5–7 drive 8'h00.
- bus_2 is combinational from sel_bus_2_mux. Code 3 drives 8'h00.
- ALU operands: a = Y, b = bus_1. The opcode is IR[7:4].
  - NOP (0): 0
  - ADD (1): a+b
  - SUB (2): b−a
  - AND (3): a&b
  - NOT (4): ~b
  - All other opcodes: 0
- ALU results are 8-bit modulo; carry and borrow are discarded. alu_out is combinational.
- PC arithmetic is 8-bit wrap: 8'hFF+1 = 8'h00.
- If load_pc and inc_pc are both 1, load_pc wins.
- Multiple Rn loads in one cycle are legal; all selected registers capture the same bus_2 value.
- Loading a register that is also the bus_2 source captures the pre-edge value, so there is no combinational loop.
- Z is written only on load_z and reflects alu_out computed with the pre-edge IR and Y.

## Timing
- Synchronous reset: while rst = 0 at a rising edge, all registers clear to 0. Resulting outputs: instruction = 8'h00, zero = 0, address = 8'h00, bus_1 = R0 = 8'h00.
- Reset overrides every strobe in the same cycle. Reset mid-instruction simply clears state; no partial update survives.
- Register latency: a strobe asserted in cycle n makes the new value visible on outputs after edge n.
- bus_1 and bus_2 have zero latency.
- Memory read path: mem_word must be valid in the same cycle as load_ir, load_pc, load_addr_reg or load_rn with sel_bus_2_mux = 2.
- Write path: bus_1 must be stable during the cycle the control unit asserts write. This block does not consume write.

## Structure
- Shared package `cpu_pkg` holds:
  - word_size
  - opcode constants NOP, ADD, SUB, AND, NOT, RD, WR, BR, BRZ
  - register codes r0–r3
  - bus-1 select codes (SEL1_R0…SEL1_PC)
  - bus-2 select codes (SEL2_ALU, SEL2_BUS1, SEL2_MEM)

  The control unit imports the same package.
- One sub-module, `alu_unit`: purely combinational (a, b, opcode → alu_out). Z generation stays in processing_unit.
- Registers live in the top module, each as an enabled flip-flop with a synchronous clear.

## Test plan
- Reset: R0 = 8'h55 and PC = 8'h10 loaded, then rst = 0 for one edge → all outputs 0 on the next cycle; strobes asserted during reset are ignored.
- Fetch: PC = 8'h07, sel1 = 4, sel2 = 1, load_addr_reg → address = 8'h07. Next cycle mem_word = 8'h1B, sel2 = 2, load_ir, inc_pc → instruction = 8'h1B, PC = 8'h08.
- ADD with wrap: R2 = 8'hF0 into Y; IR = 8'h1_? with src R3 = 8'h20; sel1 = 3, sel2 = 0, load_r1, load_z → R1 = 8'h10, zero = 0.
- SUB to zero: Y = 8'h33, bus_1 = 8'h33, IR opcode 2, load_r0, load_z → R0 = 8'h00, zero = 1. A later load_z with ADD 1+1 → zero = 0.
- PC priority and wrap: PC = 8'hFF with inc_pc alone → 8'h00. load_pc and inc_pc together with bus_2 = 8'h40 → PC = 8'h40.
- Illegal selects: sel1 = 6 → bus_1 = 8'h00; sel2 = 3 with load_r3 → R3 = 8'h00; opcode 4'hF with load_z → zero = 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: widths, opcodes, register codes
// and bus mux select codes. Imported by the datapath and the control unit.
package cpu_pkg;

    localparam int unsigned word_size   = 8;
    localparam int unsigned opcode_size = 4;
    localparam int unsigned sel1_size   = 3;
    localparam int unsigned sel2_size   = 2;

    // Instruction opcodes (IR[7:4])
    localparam logic [opcode_size-1:0] NOP = 4'd0;
    localparam logic [opcode_size-1:0] ADD = 4'd1;
    localparam logic [opcode_size-1:0] SUB = 4'd2;
    localparam logic [opcode_size-1:0] AND = 4'd3;
    localparam logic [opcode_size-1:0] NOT = 4'd4;
    localparam logic [opcode_size-1:0] RD  = 4'd5;
    localparam logic [opcode_size-1:0] WR  = 4'd6;
    localparam logic [opcode_size-1:0] BR  = 4'd7;
    localparam logic [opcode_size-1:0] BRZ = 4'd8;

    // General-purpose register codes
    localparam logic [1:0] r0 = 2'd0;
    localparam logic [1:0] r1 = 2'd1;
    localparam logic [1:0] r2 = 2'd2;
    localparam logic [1:0] r3 = 2'd3;

    // Bus-1 source selects
    localparam logic [sel1_size-1:0] SEL1_R0 = 3'd0;
    localparam logic [sel1_size-1:0] SEL1_R1 = 3'd1;
    localparam logic [sel1_size-1:0] SEL1_R2 = 3'd2;
    localparam logic [sel1_size-1:0] SEL1_R3 = 3'd3;
    localparam logic [sel1_size-1:0] SEL1_PC = 3'd4;

    // Bus-2 source selects
    localparam logic [sel2_size-1:0] SEL2_ALU  = 2'd0;
    localparam logic [sel2_size-1:0] SEL2_BUS1 = 2'd1;
    localparam logic [sel2_size-1:0] SEL2_MEM  = 2'd2;

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU of the datapath.
// Ports: a (Y register), b (bus_1), opcode (IR[7:4]) -> alu_out (8-bit modulo).
module alu_unit
    import cpu_pkg::*;
(
    input  logic [word_size-1:0]   a,
    input  logic [word_size-1:0]   b,
    input  logic [opcode_size-1:0] opcode,
    output logic [word_size-1:0]   alu_out
);

    // Result select; carry/borrow are dropped by the 8-bit width
    always_comb begin
        alu_out = '0;
        case (opcode)
            ADD:     alu_out = word_size'(a + b);
            SUB:     alu_out = word_size'(b - a);
            AND:     alu_out = a & b;
            NOT:     alu_out = ~b;
            default: alu_out = '0;
        endcase
    end

endmodule

// File: rtl/processing_unit.sv
// Datapath of the 8-bit RISC CPU: R0-R3, PC, IR, Y, Z and the memory address
// register, connected through two internal buses and the ALU.
// Ports:
//   clk, rst (sync, active-low)
//   load_r0..load_r3, load_pc, inc_pc, load_ir, load_y, load_z, load_addr_reg
//   sel_bus_1_mux (R0..R3, PC), sel_bus_2_mux (ALU, bus_1, mem_word)
//   mem_word       memory read data
//   instruction    IR contents to the control unit
//   zero           Z flag to the control unit
//   address        address register to memory
//   bus_1          bus-1 value, also memory write data (combinational)
module processing_unit
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_r0,
    input  logic                 load_r1,
    input  logic                 load_r2,
    input  logic                 load_r3,
    input  logic                 load_pc,
    input  logic                 inc_pc,
    input  logic                 load_ir,
    input  logic                 load_y,
    input  logic                 load_z,
    input  logic                 load_addr_reg,
    input  logic [sel1_size-1:0] sel_bus_1_mux,
    input  logic [sel2_size-1:0] sel_bus_2_mux,
    input  logic [word_size-1:0] mem_word,
    output logic [word_size-1:0] instruction,
    output logic                 zero,
    output logic [word_size-1:0] address,
    output logic [word_size-1:0] bus_1
);

    logic [word_size-1:0] r_r0, r_r1, r_r2, r_r3;
    logic [word_size-1:0] r_pc, r_ir, r_y, r_addr;
    logic                 r_z;

    logic [word_size-1:0] w_bus_1;
    logic [word_size-1:0] w_bus_2;
    logic [word_size-1:0] w_alu_out;

    // Bus-1 source mux; unused codes drive zero
    always_comb begin
        w_bus_1 = '0;
        case (sel_bus_1_mux)
            SEL1_R0: w_bus_1 = r_r0;
            SEL1_R1: w_bus_1 = r_r1;
            SEL1_R2: w_bus_1 = r_r2;
            SEL1_R3: w_bus_1 = r_r3;
            SEL1_PC: w_bus_1 = r_pc;
            default: w_bus_1 = '0;
        endcase
    end

    // Bus-2 source mux; unused code drives zero
    always_comb begin
        w_bus_2 = '0;
        case (sel_bus_2_mux)
            SEL2_ALU:  w_bus_2 = w_alu_out;
            SEL2_BUS1: w_bus_2 = w_bus_1;
            SEL2_MEM:  w_bus_2 = mem_word;
            default:   w_bus_2 = '0;
        endcase
    end

    alu_unit u_alu (
        .a       (r_y),
        .b       (w_bus_1),
        .opcode  (r_ir[word_size-1 -: opcode_size]),
        .alu_out (w_alu_out)
    );

    // General-purpose registers; several may capture bus_2 in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_r0 <= '0;
            r_r1 <= '0;
            r_r2 <= '0;
            r_r3 <= '0;
        end else begin
            if (load_r0) r_r0 <= w_bus_2;
            if (load_r1) r_r1 <= w_bus_2;
            if (load_r2) r_r2 <= w_bus_2;
            if (load_r3) r_r3 <= w_bus_2;
        end
    end

    // Program counter: load has priority over increment, increment wraps
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= '0;
        end else if (load_pc) begin
            r_pc <= w_bus_2;
        end else if (inc_pc) begin
            r_pc <= word_size'(r_pc + word_size'(1));
        end
    end

    // Instruction, operand and address registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ir   <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else begin
            if (load_ir)       r_ir   <= w_bus_2;
            if (load_y)        r_y    <= w_bus_2;
            if (load_addr_reg) r_addr <= w_bus_2;
        end
    end

    // Zero flag from the ALU result of the current IR and Y
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_z <= 1'b0;
        end else if (load_z) begin
            r_z <= (w_alu_out == '0);
        end
    end

    assign instruction = r_ir;
    assign zero        = r_z;
    assign address     = r_addr;
    assign bus_1       = w_bus_1;

endmodule

// File: tb/tb_processing_unit.sv
// Directed self-checking bench for processing_unit.
module tb_processing_unit;
    import cpu_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 load_r0, load_r1, load_r2, load_r3;
    logic                 load_pc, inc_pc, load_ir, load_y, load_z, load_addr_reg;
    logic [sel1_size-1:0] sel_bus_1_mux;
    logic [sel2_size-1:0] sel_bus_2_mux;
    logic [word_size-1:0] mem_word;
    logic [word_size-1:0] instruction;
    logic                 zero;
    logic [word_size-1:0] address;
    logic [word_size-1:0] bus_1;

    int checks = 0;
    int errors = 0;

    processing_unit dut (
        .clk           (clk),
        .rst           (rst),
        .load_r0       (load_r0),
        .load_r1       (load_r1),
        .load_r2       (load_r2),
        .load_r3       (load_r3),
        .load_pc       (load_pc),
        .inc_pc        (inc_pc),
        .load_ir       (load_ir),
        .load_y        (load_y),
        .load_z        (load_z),
        .load_addr_reg (load_addr_reg),
        .sel_bus_1_mux (sel_bus_1_mux),
        .sel_bus_2_mux (sel_bus_2_mux),
        .mem_word      (mem_word),
        .instruction   (instruction),
        .zero          (zero),
        .address       (address),
        .bus_1         (bus_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        load_r0 = 0; load_r1 = 0; load_r2 = 0; load_r3 = 0;
        load_pc = 0; inc_pc = 0; load_ir = 0; load_y = 0; load_z = 0;
        load_addr_reg = 0;
        sel_bus_1_mux = 3'd0; sel_bus_2_mux = 2'd0; mem_word = 8'h00;
    endtask

    // Apply the current strobes for one edge, then release them
    task automatic tick();
        @(posedge clk);
        #1;
        clr();
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus1(input string tag, input logic [2:0] sel, input logic [7:0] exp);
        sel_bus_1_mux = sel;
        #1;
        check(tag, bus_1, exp);
        sel_bus_1_mux = 3'd0;
        #1;
    endtask

    task automatic mem_load_pc(input logic [7:0] v);
        mem_word = v; sel_bus_2_mux = SEL2_MEM; load_pc = 1;
        tick();
    endtask

    initial begin
        clr();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;

        // Reset test: preload R0 and PC, then reset with strobes active
        mem_word = 8'h55; sel_bus_2_mux = SEL2_MEM; load_r0 = 1; tick();
        mem_load_pc(8'h10);
        chk_bus1("pre_r0", SEL1_R0, 8'h55);
        chk_bus1("pre_pc", SEL1_PC, 8'h10);
        rst = 0;
        mem_word = 8'hAA; sel_bus_2_mux = SEL2_MEM;
        load_r0 = 1; load_pc = 1; load_ir = 1; load_addr_reg = 1; load_y = 1;
        tick();
        rst = 1;
        check("rst_instr", instruction, 8'h00);
        check("rst_zero", {7'd0, zero}, 8'h00);
        check("rst_addr", address, 8'h00);
        chk_bus1("rst_r0", SEL1_R0, 8'h00);
        chk_bus1("rst_pc", SEL1_PC, 8'h00);

        // Fetch
        mem_load_pc(8'h07);
        sel_bus_1_mux = SEL1_PC; sel_bus_2_mux = SEL2_BUS1; load_addr_reg = 1; tick();
        check("fetch_addr", address, 8'h07);
        mem_word = 8'h1B; sel_bus_2_mux = SEL2_MEM; load_ir = 1; inc_pc = 1; tick();
        check("fetch_ir", instruction, 8'h1B);
        chk_bus1("fetch_pc", SEL1_PC, 8'h08);

        // ADD with wrap: Y=F0 (from R2), R3=20, F0+20 = 10
        mem_word = 8'hF0; sel_bus_2_mux = SEL2_MEM; load_r2 = 1; tick();
        mem_word = 8'h20; sel_bus_2_mux = SEL2_MEM; load_r3 = 1; tick();
        sel_bus_1_mux = SEL1_R2; sel_bus_2_mux = SEL2_BUS1; load_y = 1; tick();
        mem_word = 8'h13; sel_bus_2_mux = SEL2_MEM; load_ir = 1; tick();
        sel_bus_1_mux = SEL1_R3; sel_bus_2_mux = SEL2_ALU; load_r1 = 1; load_z = 1; tick();
        chk_bus1("add_r1", SEL1_R1, 8'h10);
        check("add_zero", {7'd0, zero}, 8'h00);

        // SUB to zero: Y=33, R0=33, 33-33 = 0
        mem_word = 8'h33; sel_bus_2_mux = SEL2_MEM; load_y = 1; load_r0 = 1; tick();
        mem_word = 8'h20; sel_bus_2_mux = SEL2_MEM; load_ir = 1; tick();
        sel_bus_1_mux = SEL1_R0; sel_bus_2_mux = SEL2_ALU; load_r0 = 1; load_z = 1; tick();
        chk_bus1("sub_r0", SEL1_R0, 8'h00);
        check("sub_zero", {7'd0, zero}, 8'h01);

        // SUB ordering b-a: Y=01, R1=10 -> 0F
        mem_word = 8'h01; sel_bus_2_mux = SEL2_MEM; load_y = 1; tick();
        sel_bus_1_mux = SEL1_R1; sel_bus_2_mux = SEL2_ALU; load_r3 = 1; tick();
        chk_bus1("sub_order", SEL1_R3, 8'h0F);

        // ADD 1+1 clears Z
        mem_word = 8'h01; sel_bus_2_mux = SEL2_MEM; load_y = 1; load_r1 = 1; tick();
        mem_word = 8'h11; sel_bus_2_mux = SEL2_MEM; load_ir = 1; tick();
        sel_bus_1_mux = SEL1_R1; sel_bus_2_mux = SEL2_ALU; load_z = 1; load_r2 = 1; tick();
        check("add11_zero", {7'd0, zero}, 8'h00);
        chk_bus1("add11_r2", SEL1_R2, 8'h02);

        // AND: Y=3C, R3=0F -> 0C ; NOT: ~R3 -> F0
        mem_word = 8'h3C; sel_bus_2_mux = SEL2_MEM; load_y = 1; tick();
        mem_word = 8'h30; sel_bus_2_mux = SEL2_MEM; load_ir = 1; tick();
        sel_bus_1_mux = SEL1_R3; sel_bus_2_mux = SEL2_ALU; load_r0 = 1; tick();
        chk_bus1("and_r0", SEL1_R0, 8'h0C);
        mem_word = 8'h40; sel_bus_2_mux = SEL2_MEM; load_ir = 1; tick();
        sel_bus_1_mux = SEL1_R3; sel_bus_2_mux = SEL2_ALU; load_r1 = 1; tick();
        chk_bus1("not_r1", SEL1_R1, 8'hF0);

        // Multiple register loads, and self-load through bus_1
        mem_word = 8'hA5; sel_bus_2_mux = SEL2_MEM;
        load_r0 = 1; load_r1 = 1; load_r2 = 1; load_r3 = 1; tick();
        chk_bus1("multi_r0", SEL1_R0, 8'hA5);
        chk_bus1("multi_r3", SEL1_R3, 8'hA5);
        sel_bus_1_mux = SEL1_R2; sel_bus_2_mux = SEL2_BUS1; load_r2 = 1; tick();
        chk_bus1("self_r2", SEL1_R2, 8'hA5);

        // PC wrap and load priority
        mem_load_pc(8'hFF);
        inc_pc = 1; tick();
        chk_bus1("pc_wrap", SEL1_PC, 8'h00);
        mem_word = 8'h40; sel_bus_2_mux = SEL2_MEM; load_pc = 1; inc_pc = 1; tick();
        chk_bus1("pc_prio", SEL1_PC, 8'h40);
        tick();
        chk_bus1("pc_hold", SEL1_PC, 8'h40);

        // Illegal selects and opcode
        chk_bus1("sel1_5", 3'd5, 8'h00);
        chk_bus1("sel1_6", 3'd6, 8'h00);
        chk_bus1("sel1_7", 3'd7, 8'h00);
        sel_bus_2_mux = 2'd3; load_r3 = 1; mem_word = 8'h77; tick();
        chk_bus1("sel2_3", SEL1_R3, 8'h00);
        mem_word = 8'hF0; sel_bus_2_mux = SEL2_MEM; load_ir = 1; tick();
        sel_bus_1_mux = SEL1_R0; load_z = 1; tick();
        check("opF_zero", {7'd0, zero}, 8'h01);
        check("hold_addr", address, 8'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
